mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Load/store stage between the execute pipeline and the single-port `data_memory` block. It accepts one memory request at a time through a valid/ready handshake. It drives the `data_memory` read/write strobes with word-aligned addresses and performs read-modify-write for byte and halfword stores. Load data is sign- or zero-extended before being returned to write-back.

## Interface
Parameters:
- `AW`, 32: byte-address width.
- `DW`, 32: data width. Fixed at 32; other values are unsupported.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  stage idle, can accept a request.
- `req_load`  in  1  load request.
- `req_store`  in  1  store request.
- `req_size`  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned`  in  1  zero-extend load result when 1.
- `req_addr`  in  AW  byte address.
- `req_wdata`  in  DW  store data, LSB-justified.
- `req_rd`  in  5  destination tag, returned unchanged.
- `mem_addr`  out  32  word index, equal to captured `addr >> 2`.
- `mem_wdata`  out  32  `data_memory` write data.
- `mem_rdata`  in  32  `data_memory` read data, combinational.
- `mem_read`  out  1  read strobe.
- `mem_write`  out  1  write strobe.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_data`  out  32  extended load data; 0 for stores and errors.
- `resp_rd`  out  5  tag of the completed request.
- `resp_err`  out  1  illegal or misaligned request.

## Operation
- States:
  - IDLE.
  - RD: load read.
  - RMW_RD: sub-word store read.
  - WR: write.
  - ERR.
- Handshake:
  - `req_ready` = (state == IDLE).
  - A request is accepted on an edge where `req_valid & req_ready` is true.
  - All `req_*` fields are captured into internal registers on acceptance.
- Transitions from IDLE on acceptance:
  - Illegal request → ERR. Illegal means:
    - `req_size`=11,
    - `req_load & req_store`, or
    - misaligned (see Configuration).
  - Load → RD.
  - Word store → WR.
  - Byte or half store → RMW_RD.
  - Neither load nor store → ERR-free ack: go directly to IDLE and pulse `resp_valid` with `resp_err`=0 and `resp_data`=0.
- RD:
  - `mem_read`=1.
  - `mem_rdata` lane is selected by `addr[1:0]` and extended, then registered into `resp_data`.
  - Next state IDLE.
- RMW_RD:
  - `mem_read`=1.
  - `mem_rdata` is merged with captured `wdata` at lane `addr[1:0]` into a merge register.
  - Next state WR.
- WR:
  - `mem_write`=1.
  - `mem_wdata` = merge register (sub-word) or captured `wdata` (word).
  - Next state IDLE.
- ERR:
  - No memory strobes.
  - Next state IDLE with `resp_err`=1.
- Lane selection, little-endian:
  - Byte lane n = bits [8n+7:8n].
  - Halfword uses `addr[1]`.
- `resp_*` are registered:
  - They are valid in the cycle the FSM returns to IDLE.
  - They hold for exactly one cycle.
  - There is no backpressure.
- `mem_*` are driven only from state and capture registers. There is no combinational path from `req_*`.
- `mem_read` and `mem_write` are never both 1.
- `mem_addr` and `mem_wdata` are stable for the whole strobe cycle.

## Timing
- Reset values:
  - State IDLE, `req_ready`=1.
  - `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
  - `resp_valid`=0, `resp_data`=0, `resp_rd`=0, `resp_err`=0.
- Latency from the acceptance edge (cycle 0) to the `resp_valid` cycle:
  - Load: 2.
  - Word store: 2.
  - Sub-word store: 3.
  - Error: 2.
  - No-op: 1.
- `req_ready` rises in the same cycle as `resp_valid`, so back-to-back requests are allowed.
- Reset asserted mid-operation:
  - Strobes drop immediately.
  - The in-flight request is dropped.
  - No response is produced.
- A request presented while `req_ready`=0 is ignored. The source must hold it.

## Configuration
- `MEM_STAGE_MISALIGN_TRAP_EN`:
  - Defined: a half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, goes to ERR and `resp_err`=1. No memory access occurs.
  - Undefined: the offending low address bits are forced to 0 (half ignores `addr[0]`; word ignores `addr[1:0]`) and the access proceeds normally.
  - `req_size`=11 and load+store remain errors in both builds.

## Structure
- Package `mem_stage_pkg` holds:
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - The FSM state enum.
  - The response-error encoding.
- Sub-module `mem_lane_align` is purely combinational:
  - Extracts and extends the load lane.
  - Performs the store merge.
  - It is instantiated once and shared by RD and RMW_RD.

## Test plan
- Load byte:
  - Stimulus: memory word 0x0000000A holds 0x80FF7F01; load byte at addr 0x2B, signed.
  - Expected: `mem_addr`=0x0A; `resp_data`=0xFFFFFF80 two cycles after acceptance.
  - Repeat unsigned. Expected: 0x00000080.
- Word store:
  - Stimulus: store 0xABCD0000 at addr 0x28.
  - Expected: exactly one `mem_write` cycle with `mem_addr`=0x0A and `mem_wdata`=0xABCD0000. `resp_valid` 2 cycles after acceptance.
- Halfword store RMW:
  - Stimulus: memory word 0x03 holds 0x11223344; store half 0xBEEF at addr 0x0E.
  - Expected: RMW_RD cycle, then WR with `mem_wdata`=0xBEEF3344. Response at 3 cycles.
- Misaligned word:
  - Stimulus: load word at addr 0x0D.
  - With `MEM_STAGE_MISALIGN_TRAP_EN`: `resp_err`=1, no strobes.
  - Without it: reads word 0x03.
- Back-to-back:
  - Stimulus: store then load to the same address on consecutive ready cycles.
  - Expected: the load returns the stored value. `req_ready` is low only while busy.
- Reset mid-RMW:
  - Stimulus: assert `rst_n`=0 during RMW_RD.
  - Expected: no `mem_write`, no `resp_valid`, and all outputs at reset values.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the load/store stage: access sizes, FSM states,
// response-error code and the captured-request payload.
package mem_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WR     = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  typedef enum logic {
    RESP_OK  = 1'b0,
    RESP_ERR = 1'b1
  } resp_err_e;

  // Fields of an accepted request still needed after the acceptance edge.
  // Only the low halfword of store data is kept: word stores load the
  // write-data register directly at acceptance.
  typedef struct packed {
    logic [1:0]       size;
    logic             is_unsigned;
    logic [1:0]       offset;
    logic [TAG_W-1:0] rd;
    logic [15:0]      wdata_lo;
  } req_cap_t;

endpackage

// File: rtl/mem_access_stage_lane.sv
// mem_lane_align: combinational lane extract/extend for loads and
// byte/halfword merge for read-modify-write stores (little-endian lanes).
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [15:0] i_wdata,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_load_data_c,
  output logic [31:0] o_merge_data_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_mask;
  logic [31:0] w_ins;

  // Select the addressed lane and sign/zero extend it.
  always_comb begin
    w_byte = 8'(i_rdata >> {i_offset, 3'b000});
    w_half = 16'(i_rdata >> {i_offset[1], 4'b0000});
    case (i_size)
      SZ_BYTE: o_load_data_c = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: o_load_data_c = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_load_data_c = i_rdata;
    endcase
  end

  // Replace the addressed lane of the read word with the store data.
  always_comb begin
    case (i_size)
      SZ_BYTE: begin
        w_mask = 32'h0000_00FF << {i_offset, 3'b000};
        w_ins  = {24'h0, i_wdata[7:0]} << {i_offset, 3'b000};
      end
      SZ_HALF: begin
        w_mask = 32'h0000_FFFF << {i_offset[1], 4'b0000};
        w_ins  = {16'h0, i_wdata} << {i_offset[1], 4'b0000};
      end
      default: begin
        w_mask = 32'h0;
        w_ins  = 32'h0;
      end
    endcase
    o_merge_data_c = (i_rdata & ~w_mask) | w_ins;
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: one-at-a-time load/store stage in front of a
// single-port data memory. Sub-word stores use read-modify-write.
// Optional build macro MEM_STAGE_MISALIGN_TRAP_EN: misaligned half/word
// accesses trap with resp_err instead of being force-aligned.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_load,
  input  logic          req_store,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [4:0]    req_rd,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic          resp_valid,
  output logic [31:0]   resp_data,
  output logic [4:0]    resp_rd,
  output logic          resp_err
);

  state_e      r_state;
  state_e      w_state_nxt;
  req_cap_t    r_req;
  req_cap_t    w_req_nxt;
  logic        r_ready;
  logic [31:0] r_mem_addr;
  logic [31:0] w_mem_addr_nxt;
  logic [31:0] r_mem_wdata;
  logic [31:0] w_mem_wdata_nxt;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_resp_valid;
  logic        w_resp_valid_nxt;
  logic [31:0] r_resp_data;
  logic [31:0] w_resp_data_nxt;
  logic [4:0]  r_resp_rd;
  logic [4:0]  w_resp_rd_nxt;
  logic        r_resp_err;
  logic        w_resp_err_nxt;
  logic        w_accept;
  logic        w_misalign;
  logic        w_illegal;
  logic [AW-1:0] w_addr_eff;
  logic [31:0] w_load_data_c;
  logic [31:0] w_merge_data_c;

  assign w_accept  = req_valid & r_ready;
  assign w_illegal = (req_size == SZ_RSVD) | (req_load & req_store) | w_misalign;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  // Misaligned half/word requests are flagged and take the error path.
  always_comb begin
    w_misalign = ((req_size == SZ_HALF) & req_addr[0]) |
                 ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));
    w_addr_eff = req_addr;
  end
`else
  // Misaligned half/word requests are silently aligned down.
  always_comb begin
    w_misalign = 1'b0;
    w_addr_eff = req_addr;
    if (req_size == SZ_HALF) w_addr_eff[0]   = 1'b0;
    if (req_size == SZ_WORD) w_addr_eff[1:0] = 2'b00;
  end
`endif

  mem_lane_align u_lane (
    .i_rdata        (mem_rdata),
    .i_wdata        (r_req.wdata_lo),
    .i_offset       (r_req.offset),
    .i_size         (r_req.size),
    .i_unsigned     (r_req.is_unsigned),
    .o_load_data_c  (w_load_data_c),
    .o_merge_data_c (w_merge_data_c)
  );

  // Next-state and next-value logic for the request FSM and its outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_req_nxt        = r_req;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_resp_valid_nxt = 1'b0;
    w_resp_data_nxt  = 32'h0;
    w_resp_rd_nxt    = r_resp_rd;
    w_resp_err_nxt   = RESP_OK;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_req_nxt.size        = req_size;
          w_req_nxt.is_unsigned = req_unsigned;
          w_req_nxt.offset      = w_addr_eff[1:0];
          w_req_nxt.rd          = req_rd;
          w_req_nxt.wdata_lo    = req_wdata[15:0];
          w_mem_addr_nxt        = 32'(w_addr_eff >> 2);
          if (w_illegal) begin
            w_state_nxt = ST_ERR;
          end else if (req_load) begin
            w_state_nxt = ST_RD;
          end else if (req_store) begin
            if (req_size == SZ_WORD) begin
              w_state_nxt     = ST_WR;
              w_mem_wdata_nxt = 32'(req_wdata);
            end else begin
              w_state_nxt = ST_RMW_RD;
            end
          end else begin
            w_resp_valid_nxt = 1'b1;
            w_resp_rd_nxt    = req_rd;
          end
        end
      end
      ST_RD: begin
        w_state_nxt      = ST_IDLE;
        w_resp_valid_nxt = 1'b1;
        w_resp_data_nxt  = w_load_data_c;
        w_resp_rd_nxt    = r_req.rd;
      end
      ST_RMW_RD: begin
        w_state_nxt     = ST_WR;
        w_mem_wdata_nxt = w_merge_data_c;
      end
      ST_WR: begin
        w_state_nxt      = ST_IDLE;
        w_resp_valid_nxt = 1'b1;
        w_resp_rd_nxt    = r_req.rd;
      end
      ST_ERR: begin
        w_state_nxt      = ST_IDLE;
        w_resp_valid_nxt = 1'b1;
        w_resp_err_nxt   = RESP_ERR;
        w_resp_rd_nxt    = r_req.rd;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Capture, memory-strobe and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req        <= '0;
      r_ready      <= 1'b1;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'h0;
      r_resp_rd    <= 5'h0;
      r_resp_err   <= 1'b0;
    end else begin
      r_req        <= w_req_nxt;
      r_ready      <= (w_state_nxt == ST_IDLE);
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_mem_read   <= (w_state_nxt == ST_RD) | (w_state_nxt == ST_RMW_RD);
      r_mem_write  <= (w_state_nxt == ST_WR);
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_data  <= w_resp_data_nxt;
      r_resp_rd    <= w_resp_rd_nxt;
      r_resp_err   <= w_resp_err_nxt;
    end
  end

  assign req_ready  = r_ready;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_rd    = r_resp_rd;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized traffic
// checked against a byte-level memory reference model.
module tb_mem_access_stage;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_load = 1'b0;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'h0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;

  always #5 clk = ~clk;

  mem_access_stage #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
    .resp_err(resp_err)
  );

  // Environment data memory: 64 words, combinational read.
  logic [31:0] mem [64];
  logic        fill_en = 1'b0;
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = 6'h0;
  logic [31:0] pre_val = 32'h0;

  assign mem_rdata = mem[mem_addr[5:0]];

  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i) * 32'h9E37_79B1;
    end else if (pre_we) begin
      mem[pre_idx] <= pre_val;
    end else if (mem_write) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
  end

  // Reference memory and expectations.
  logic [31:0] ref_mem [64];
  int          e_lat, e_reads, e_writes;
  logic [31:0] e_data, e_addr, e_wdata;
  logic        e_err;

  // Observations of one transaction.
  int          obs_lat, obs_reads, obs_writes, obs_both, obs_busy;
  logic [31:0] obs_data, obs_raddr, obs_waddr, obs_wdata;
  logic        obs_err, obs_ready;
  logic [4:0]  obs_rd;

  int n_err = 0;
  int n_chk = 0;

  // Reference: what one request should do, in terms of memory bytes.
  task automatic model_req(input logic ld, input logic st, input logic [1:0] sz,
                           input logic un, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] a, w, v;
    int nb, off, widx;
    bit bad;
    nb  = 1 << sz;
    bad = (sz == 2'd3) || (ld && st);
    if (TRAP && sz != 2'd3 && (addr % nb) != 0) bad = 1'b1;
    a = addr;
    if (!TRAP && sz != 2'd3) a = addr - (addr % nb);
    widx = int'(a / 4);
    off  = int'(a % 4);
    e_addr = a / 4; e_data = 32'h0; e_err = 1'b0;
    e_reads = 0; e_writes = 0; e_wdata = 32'h0; e_lat = 1;
    if (bad) begin
      e_err = 1'b1; e_lat = 2;
    end else if (ld) begin
      w = ref_mem[widx];
      v = 32'h0;
      for (int b = 0; b < nb; b++) v[8*b +: 8] = w[8*(off+b) +: 8];
      if (!un && nb < 4 && v[8*nb-1]) for (int b = nb; b < 4; b++) v[8*b +: 8] = 8'hFF;
      e_data = v; e_lat = 2; e_reads = 1;
    end else if (st) begin
      w = ref_mem[widx];
      for (int b = 0; b < nb; b++) w[8*(off+b) +: 8] = wd[8*b +: 8];
      ref_mem[widx] = w;
      e_wdata = w; e_writes = 1;
      e_reads = (nb < 4) ? 1 : 0;
      e_lat   = (nb < 4) ? 3 : 2;
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = 6'(idx); pre_val = val;
    @(posedge clk); #1;
    pre_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Drive one request and record what the DUT does until its response.
  task automatic run_req(input logic ld, input logic st, input logic [1:0] sz,
                         input logic un, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
    int w;
    @(negedge clk);
    req_valid = 1'b1; req_load = ld; req_store = st; req_size = sz;
    req_unsigned = un; req_addr = addr; req_wdata = wd; req_rd = rd;
    w = 0;
    while (!req_ready && w < 16) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
    obs_lat = 0; obs_reads = 0; obs_writes = 0; obs_both = 0; obs_busy = 0;
    obs_data = 32'h0; obs_raddr = 32'h0; obs_waddr = 32'h0; obs_wdata = 32'h0;
    obs_err = 1'b0; obs_rd = 5'h0; obs_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (mem_read) begin obs_reads++; obs_raddr = mem_addr; end
      if (mem_write) begin obs_writes++; obs_waddr = mem_addr; obs_wdata = mem_wdata; end
      if (mem_read && mem_write) obs_both++;
      if (resp_valid) begin
        obs_lat = i; obs_data = resp_data; obs_err = resp_err;
        obs_rd = resp_rd; obs_ready = req_ready;
        break;
      end
      if (!req_ready) obs_busy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    fill_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fill_en = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i) * 32'h9E37_79B1;
    n_chk++; if ({req_ready, mem_read, mem_write, resp_valid, resp_err} !== 5'b10000) begin
      n_err++; $display("FAIL reset_flags got %b want 10000", {req_ready, mem_read, mem_write, resp_valid, resp_err}); end
    n_chk++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_err++; $display("FAIL reset_mem got addr=%h wdata=%h want 0", mem_addr, mem_wdata); end
    n_chk++; if (resp_data !== 32'h0 || resp_rd !== 5'h0) begin
      n_err++; $display("FAIL reset_resp got data=%h rd=%h want 0", resp_data, resp_rd); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset got ready=%b valid=%b want 1 0", req_ready, resp_valid); end
  endtask

  task automatic test_load_byte;
    preload(10, 32'h80FF_7F01);
    model_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h2B, 32'h0);
    run_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h2B, 32'h0, 5'd7);
    n_chk++; if (obs_raddr !== 32'h0A || obs_reads !== 1) begin
      n_err++; $display("FAIL lb_addr got %h x%0d want 0a x1", obs_raddr, obs_reads); end
    n_chk++; if (obs_data !== 32'hFFFF_FF80 || obs_lat !== 2) begin
      n_err++; $display("FAIL lb_signed got %h lat %0d want ffffff80 lat 2", obs_data, obs_lat); end
    n_chk++; if (obs_rd !== 5'd7 || obs_err !== 1'b0) begin
      n_err++; $display("FAIL lb_tag got rd=%0d err=%b want 7 0", obs_rd, obs_err); end
    run_req(1'b1, 1'b0, 2'b00, 1'b1, 32'h2B, 32'h0, 5'd8);
    n_chk++; if (obs_data !== 32'h0000_0080 || obs_lat !== 2) begin
      n_err++; $display("FAIL lb_unsigned got %h lat %0d want 00000080 lat 2", obs_data, obs_lat); end
  endtask

  task automatic test_word_store;
    model_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h28, 32'hABCD_0000);
    run_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h28, 32'hABCD_0000, 5'd3);
    n_chk++; if (obs_writes !== 1 || obs_reads !== 0) begin
      n_err++; $display("FAIL sw_strobes got w=%0d r=%0d want 1 0", obs_writes, obs_reads); end
    n_chk++; if (obs_waddr !== 32'h0A || obs_wdata !== 32'hABCD_0000) begin
      n_err++; $display("FAIL sw_data got %h@%h want abcd0000@0a", obs_wdata, obs_waddr); end
    n_chk++; if (obs_lat !== 2 || obs_data !== 32'h0) begin
      n_err++; $display("FAIL sw_resp got lat %0d data %h want 2 0", obs_lat, obs_data); end
  endtask

  task automatic test_half_rmw;
    preload(3, 32'h1122_3344);
    model_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000_BEEF);
    run_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000_BEEF, 5'd4);
    n_chk++; if (obs_reads !== 1 || obs_writes !== 1 || obs_both !== 0) begin
      n_err++; $display("FAIL sh_strobes got r=%0d w=%0d both=%0d want 1 1 0", obs_reads, obs_writes, obs_both); end
    n_chk++; if (obs_wdata !== 32'hBEEF_3344 || obs_waddr !== 32'h03) begin
      n_err++; $display("FAIL sh_merge got %h@%h want beef3344@03", obs_wdata, obs_waddr); end
    n_chk++; if (obs_lat !== 3 || obs_busy !== 2) begin
      n_err++; $display("FAIL sh_latency got %0d busy %0d want 3 busy 2", obs_lat, obs_busy); end
  endtask

  task automatic test_misaligned;
    model_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0D, 32'h0);
    run_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0D, 32'h0, 5'd9);
    n_chk++; if (obs_err !== TRAP || obs_lat !== 2) begin
      n_err++; $display("FAIL lw_misalign_err got err=%b lat %0d want %b lat 2", obs_err, obs_lat, TRAP); end
    n_chk++; if (obs_reads !== (TRAP ? 0 : 1) || obs_writes !== 0) begin
      n_err++; $display("FAIL lw_misalign_strobes got r=%0d w=%0d", obs_reads, obs_writes); end
    n_chk++; if (obs_data !== (TRAP ? 32'h0 : 32'hBEEF_3344)) begin
      n_err++; $display("FAIL lw_misalign_data got %h want %h", obs_data, TRAP ? 32'h0 : 32'hBEEF_3344); end
  endtask

  task automatic test_illegal_noop;
    run_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 5'd17);
    n_chk++; if (obs_err !== 1'b1 || obs_lat !== 2 || obs_reads !== 0 || obs_rd !== 5'd17) begin
      n_err++; $display("FAIL size11 got err=%b lat %0d r=%0d rd=%0d want 1 2 0 17", obs_err, obs_lat, obs_reads, obs_rd); end
    run_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678, 5'd18);
    n_chk++; if (obs_err !== 1'b1 || obs_writes !== 0 || obs_reads !== 0 || obs_data !== 32'h0) begin
      n_err++; $display("FAIL ld_st got err=%b w=%0d r=%0d data=%h want 1 0 0 0", obs_err, obs_writes, obs_reads, obs_data); end
    run_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 5'd19);
    n_chk++; if (obs_lat !== 1 || obs_err !== 1'b0 || obs_data !== 32'h0 || obs_rd !== 5'd19 || obs_ready !== 1'b1) begin
      n_err++; $display("FAIL noop got lat %0d err=%b data=%h rd=%0d ready=%b want 1 0 0 19 1", obs_lat, obs_err, obs_data, obs_rd, obs_ready); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, d;
    for (int k = 0; k < 4; k++) begin
      a = 32'($urandom_range(0, 63)) << 2;
      d = $urandom;
      model_req(1'b0, 1'b1, 2'b10, 1'b0, a, d);
      run_req(1'b0, 1'b1, 2'b10, 1'b0, a, d, 5'(k));
      n_chk++; if (obs_busy !== 1 || obs_ready !== 1'b1) begin
        n_err++; $display("FAIL b2b_store_ready[%0d] got busy %0d ready %b want 1 1", k, obs_busy, obs_ready); end
      model_req(1'b1, 1'b0, 2'b10, 1'b0, a, 32'h0);
      run_req(1'b1, 1'b0, 2'b10, 1'b0, a, 32'h0, 5'(k + 8));
      n_chk++; if (obs_data !== d || obs_lat !== 2) begin
        n_err++; $display("FAIL b2b_load[%0d] got %h lat %0d want %h lat 2", k, obs_data, obs_lat, d); end
    end
  endtask

  task automatic test_random;
    logic ld, st, un;
    logic [1:0] sz;
    logic [31:0] a, d;
    logic [4:0] rd;
    int r;
    for (int k = 0; k < 80; k++) begin
      r  = int'($urandom_range(0, 9));
      ld = (r <= 3) || (r == 9);
      st = (r >= 4 && r <= 7) || (r == 9);
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      un = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 255));
      d  = $urandom;
      rd = 5'($urandom_range(0, 31));
      model_req(ld, st, sz, un, a, d);
      run_req(ld, st, sz, un, a, d, rd);
      n_chk++; if (obs_lat !== e_lat || obs_err !== e_err || obs_rd !== rd) begin
        n_err++; $display("FAIL rand_resp[%0d] got lat %0d err %b rd %0d want %0d %b %0d", k, obs_lat, obs_err, obs_rd, e_lat, e_err, rd); end
      n_chk++; if (obs_data !== e_data) begin
        n_err++; $display("FAIL rand_data[%0d] got %h want %h", k, obs_data, e_data); end
      n_chk++; if (obs_reads !== e_reads || obs_writes !== e_writes || obs_both !== 0 || obs_busy !== e_lat - 1) begin
        n_err++; $display("FAIL rand_strobes[%0d] got r%0d w%0d both%0d busy%0d want r%0d w%0d busy%0d", k, obs_reads, obs_writes, obs_both, obs_busy, e_reads, e_writes, e_lat - 1); end
      if (e_reads > 0) begin
        n_chk++; if (obs_raddr !== e_addr) begin
          n_err++; $display("FAIL rand_raddr[%0d] got %h want %h", k, obs_raddr, e_addr); end
      end
      if (e_writes > 0) begin
        n_chk++; if (obs_waddr !== e_addr || obs_wdata !== e_wdata) begin
          n_err++; $display("FAIL rand_write[%0d] got %h@%h want %h@%h", k, obs_wdata, obs_waddr, e_wdata, e_addr); end
      end
    end
  endtask

  task automatic test_reset_mid_rmw;
    int seen;
    preload(5, 32'h5566_7788);
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_size = 2'b01;
    req_unsigned = 1'b0; req_addr = 32'h14; req_wdata = 32'h0000_1234; req_rd = 5'd21;
    @(posedge clk); #1;
    req_valid = 1'b0; req_store = 1'b0;
    n_chk++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
      n_err++; $display("FAIL rmw_in_read got rd=%b wr=%b want 1 0", mem_read, mem_write); end
    rst_n = 1'b0;
    #1;
    n_chk++; if ({req_ready, mem_read, mem_write, resp_valid, resp_err} !== 5'b10000 ||
                 mem_addr !== 32'h0 || mem_wdata !== 32'h0 || resp_data !== 32'h0 || resp_rd !== 5'h0) begin
      n_err++; $display("FAIL mid_reset_outputs got flags=%b addr=%h wdata=%h data=%h rd=%h", {req_ready, mem_read, mem_write, resp_valid, resp_err}, mem_addr, mem_wdata, resp_data, resp_rd); end
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (mem_write || resp_valid) seen++;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (mem_write || resp_valid) seen++;
    end
    n_chk++; if (seen !== 0 || mem[5] !== 32'h5566_7788) begin
      n_err++; $display("FAIL mid_reset_dropped got activity %0d word %h want 0 55667788", seen, mem[5]); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_byte();
    test_word_store();
    test_half_rmw();
    test_misaligned();
    test_illegal_noop();
    test_back_to_back();
    test_random();
    test_reset_mid_rmw();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
